// File: rtl/write_check_pkg.sv
// Shared widths, slot record layout and the chunk-index / age-compare helpers
// for the multi-record write hazard table.
package write_check_pkg;

    localparam int IDX_W   = 3;
    localparam int GRP_W   = 3;
    localparam int OFF_W   = 9;
    localparam int CHUNK_W = 6;
    localparam int CIDX_W  = GRP_W + OFF_W - CHUNK_W;
    localparam int MASK_W  = 2 ** CIDX_W;
    localparam int GRPN_W  = 5 - GRP_W;

    typedef struct packed {
        logic              valid;
        logic [IDX_W-1:0]  inst;
        logic              vdValid;
        logic [4:0]        vd;
        logic              vs1Valid;
        logic [4:0]        vs1;
        logic [4:0]        vs2;
        logic              gather;
        logic              gather16;
        logic              onlyRead;
        logic [MASK_W-1:0] mask;
    } record_t;

    function automatic logic [CIDX_W-1:0] chunkIdx(input logic [4:0]       vd,
                                                   input logic [OFF_W-1:0] offset);
        return CIDX_W'({vd[GRP_W-1:0], offset} >> CHUNK_W);
    endfunction

    // 1 when the checking instruction is younger than the record (wrap-aware).
    function automatic logic ageBlock(input logic [IDX_W-1:0] chk,
                                      input logic [IDX_W-1:0] rec);
        logic same;
        logic lt;
        same = (chk == rec);
        lt   = (chk[IDX_W-2:0] < rec[IDX_W-2:0]);
        return !(same || (lt ^ chk[IDX_W-1] ^ rec[IDX_W-1]));
    endfunction

endpackage

// File: rtl/write_check_entry.sv
// Hazard evaluation of one record slot against one check lane; purely combinational.
module write_check_entry
    import write_check_pkg::*;
(
    input  record_t            rec,
    input  logic [4:0]         chkVd,
    input  logic [OFF_W-1:0]   chkOffset,
    input  logic [IDX_W-1:0]   chkInst,
    output logic               block
);

    localparam int CPR_W = OFF_W - CHUNK_W;

    // Window bit of a mask anchored at register rs; 1 = chunk done. The lo
    // window is the anchor group, hi is the following group.
    function automatic logic winDone(input logic [MASK_W-1:0] m,
                                     input logic [GRP_W-1:0]  rs,
                                     input logic [CIDX_W-1:0] c,
                                     input logic              hi);
        logic [CIDX_W-1:0] start;
        logic [CIDX_W-1:0] idx;
        start = {rs, {CPR_W{1'b0}}};
        idx   = c - start;
        if (hi) begin
            return (c < start) ? m[idx] : 1'b1;
        end
        return (c < start) ? 1'b1 : m[idx];
    endfunction

    logic [CIDX_W-1:0] chunk;
    logic [GRPN_W-1:0] grp;
    logic [GRPN_W-1:0] vdGrp;
    logic [GRPN_W-1:0] vdGrpNext;
    logic [GRPN_W-1:0] vs1Grp;
    logic [GRPN_W-1:0] vs2Grp;
    logic [GRPN_W-1:0] vs2GrpNext;
    logic              same;
    logic              waw;
    logic              war1;
    logic              war2;

    always_comb begin
        chunk      = chunkIdx(chkVd, chkOffset);
        grp        = chkVd[4:GRP_W];
        vdGrp      = rec.vd[4:GRP_W];
        vdGrpNext  = vdGrp + GRPN_W'(1);
        vs1Grp     = rec.vs1[4:GRP_W];
        vs2Grp     = rec.vs2[4:GRP_W];
        vs2GrpNext = vs2Grp + GRPN_W'(1);
        same       = (chkInst == rec.inst);

        waw  = rec.vdValid &&
               ((!winDone(rec.mask, rec.vd[GRP_W-1:0], chunk, 1'b0) && grp == vdGrp) ||
                (!winDone(rec.mask, rec.vd[GRP_W-1:0], chunk, 1'b1) && grp == vdGrpNext));
        war1 = rec.vs1Valid && grp == vs1Grp &&
               (!winDone(rec.mask, rec.vs1[GRP_W-1:0], chunk, 1'b0) || rec.gather16);
        war2 = ((!winDone(rec.mask, rec.vs2[GRP_W-1:0], chunk, 1'b0) || rec.onlyRead || rec.gather) &&
                grp == vs2Grp) ||
               ((!winDone(rec.mask, rec.vs2[GRP_W-1:0], chunk, 1'b1) || rec.gather) &&
                grp == vs2GrpNext);

        block = rec.valid && ageBlock(chkInst, rec.inst) && !same && (waw || war1 || war2);
    end

endmodule

// File: rtl/write_check_table.sv
// Multi-record write-permission table: NR_CHECK queries per cycle, registered result, latency 1, no backpressure.
// WRITE_CHECK_BYPASS_EN: same-cycle update/retire are visible to the check compare.
module write_check_table
    import write_check_pkg::*;
#(
    parameter int NR_RECORDS = 4,
    parameter int NR_CHECK   = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      alloc_valid,
    output logic                      alloc_ready,
    input  logic [IDX_W-1:0]          alloc_inst,
    input  logic                      alloc_vd_valid,
    input  logic [4:0]                alloc_vd,
    input  logic                      alloc_vs1_valid,
    input  logic [4:0]                alloc_vs1,
    input  logic [4:0]                alloc_vs2,
    input  logic                      alloc_gather,
    input  logic                      alloc_gather16,
    input  logic                      alloc_onlyRead,
    input  logic                      upd_valid,
    input  logic [IDX_W-1:0]          upd_inst,
    input  logic [MASK_W-1:0]         upd_mask,
    input  logic                      ret_valid,
    input  logic [IDX_W-1:0]          ret_inst,
    input  logic [NR_CHECK-1:0]       chk_valid,
    input  logic [NR_CHECK*5-1:0]     chk_vd,
    input  logic [NR_CHECK*OFF_W-1:0] chk_offset,
    input  logic [NR_CHECK*IDX_W-1:0] chk_inst,
    output logic [NR_CHECK-1:0]       resp_valid,
    output logic [NR_CHECK-1:0]       resp_pass,
    output logic                      dup_err
);

    localparam int SLOT_W = (NR_RECORDS > 1) ? $clog2(NR_RECORDS) : 1;

    record_t                             slots  [NR_RECORDS];
    record_t                             effRec [NR_RECORDS];
    record_t                             newRec;
    logic [NR_RECORDS-1:0]               updHit;
    logic [NR_RECORDS-1:0]               retHit;
    logic [SLOT_W-1:0]                   freeIdx;
    logic                                anyFree;
    logic                                dupHit;
    logic                                allocFire;
    logic [NR_CHECK-1:0][NR_RECORDS-1:0] blockHit;

    // Descending scan so the lowest free slot wins.
    always_comb begin
        anyFree = 1'b0;
        freeIdx = '0;
        dupHit  = 1'b0;
        updHit  = '0;
        retHit  = '0;
        for (int i = NR_RECORDS - 1; i >= 0; i--) begin
            if (!slots[i].valid) begin
                anyFree = 1'b1;
                freeIdx = SLOT_W'(i);
            end
            dupHit    = dupHit | (slots[i].valid && slots[i].inst == alloc_inst);
            updHit[i] = upd_valid && slots[i].valid && slots[i].inst == upd_inst;
            retHit[i] = ret_valid && slots[i].valid && slots[i].inst == ret_inst;
        end
    end

    assign alloc_ready = anyFree;
    assign allocFire   = alloc_valid && anyFree;

    always_comb begin
        newRec          = '0;
        newRec.valid    = 1'b1;
        newRec.inst     = alloc_inst;
        newRec.vdValid  = alloc_vd_valid;
        newRec.vd       = alloc_vd;
        newRec.vs1Valid = alloc_vs1_valid;
        newRec.vs1      = alloc_vs1;
        newRec.vs2      = alloc_vs2;
        newRec.gather   = alloc_gather;
        newRec.gather16 = alloc_gather16;
        newRec.onlyRead = alloc_onlyRead;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NR_RECORDS; i++) begin
                slots[i] <= '0;
            end
            dup_err <= 1'b0;
        end else begin
            for (int i = 0; i < NR_RECORDS; i++) begin
                if (retHit[i]) begin
                    slots[i].valid <= 1'b0;
                end else if (updHit[i]) begin
                    slots[i].mask <= slots[i].mask | upd_mask;
                end
                if (allocFire && !dupHit && freeIdx == SLOT_W'(i)) begin
                    slots[i] <= newRec;
                end
            end
            if (allocFire && dupHit) begin
                dup_err <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NR_RECORDS; i++) begin
            effRec[i] = slots[i];
`ifdef WRITE_CHECK_BYPASS_EN
            if (updHit[i]) effRec[i].mask = slots[i].mask | upd_mask;
            if (retHit[i]) effRec[i].valid = 1'b0;
`endif
        end
    end

    for (genvar l = 0; l < NR_CHECK; l++) begin : g_lane
        for (genvar r = 0; r < NR_RECORDS; r++) begin : g_rec
            write_check_entry u_entry (
                .rec       (effRec[r]),
                .chkVd     (chk_vd[l*5 +: 5]),
                .chkOffset (chk_offset[l*OFF_W +: OFF_W]),
                .chkInst   (chk_inst[l*IDX_W +: IDX_W]),
                .block     (blockHit[l][r])
            );
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resp_valid <= '0;
            resp_pass  <= '1;
        end else begin
            for (int l = 0; l < NR_CHECK; l++) begin
                resp_valid[l] <= chk_valid[l];
                resp_pass[l]  <= chk_valid[l] ? ~|blockHit[l] : 1'b1;
            end
        end
    end

endmodule
